// File: rtl/keccak_pkg.sv
// Shared Keccak-f definitions: lane geometry, state typedefs and lane helpers.
// Used by the theta/rho/pi/chi/iota round stages.
package keccak_pkg;

    localparam int LANE_W_DEF = 64;
    localparam int NUM_LANES  = 25;
    localparam int NUM_COLS   = 5;

    typedef logic [LANE_W_DEF-1:0]           lane_t;
    typedef logic [NUM_LANES*LANE_W_DEF-1:0] state_t;

    // Lane (x, y) lives at bits [lane_idx(x,y)*LANE_W +: LANE_W] of a packed state.
    function automatic int lane_idx(input int x, input int y);
        return x + NUM_COLS * y;
    endfunction

    function automatic lane_t rol1(input lane_t c);
        return {c[LANE_W_DEF-2:0], c[LANE_W_DEF-1]};
    endfunction

endpackage

// File: rtl/theta_parity.sv
// Combinational theta column mixer: column parities C[x], then
// D[x] = C[x-1] ^ rol(C[x+1], 1) with column indices taken mod 5.
module theta_parity
    import keccak_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic [NUM_LANES*LANE_W-1:0] state_in,
    output logic [NUM_COLS*LANE_W-1:0]  d
);

    logic [LANE_W-1:0] c [NUM_COLS];

    always_comb begin
        c = '{default: '0};
        d = '0;
        for (int x = 0; x < NUM_COLS; x++) begin
            for (int y = 0; y < NUM_COLS; y++) begin
                c[x] = c[x] ^ state_in[lane_idx(x, y)*LANE_W +: LANE_W];
            end
        end
        // x-1 is written as x+4 so the mod-5 index never goes negative.
        for (int x = 0; x < NUM_COLS; x++) begin
            d[x*LANE_W +: LANE_W] = c[(x + 4) % NUM_COLS] ^
                {c[(x + 1) % NUM_COLS][LANE_W-2:0], c[(x + 1) % NUM_COLS][LANE_W-1]};
        end
    end

endmodule

// File: rtl/theta_stage.sv
// Two-stage registered Keccak-f theta step with valid/ready flow control.
// Optional per-beat pass-through enabled by the KECCAK_THETA_BYPASS_EN macro.
module theta_stage
    import keccak_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
`ifdef KECCAK_THETA_BYPASS_EN
    input  logic                        bypass,
`endif
    input  logic [NUM_LANES*LANE_W-1:0] state_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LANES*LANE_W-1:0] state_out,
    output logic                        busy
);

    localparam int STATE_W = NUM_LANES * LANE_W;
    localparam int D_W     = NUM_COLS * LANE_W;

    // Handshake: a beat moves on any cycle where valid & ready are both high.
    // A producer holds valid and data steady until that happens; ready may
    // depend combinationally on the consumer's ready, so a full pipe still
    // moves one beat per cycle.

    logic [D_W-1:0]     d_next;
    logic               s1_valid;
    logic [STATE_W-1:0] s1_state;
    logic [D_W-1:0]     s1_d;
    logic               s2_valid;
    logic               s2_ready;
    logic               s1_fire;
    logic               apply_theta;
    logic [STATE_W-1:0] theta_out;

    theta_parity #(.LANE_W(LANE_W)) u_parity (
        .state_in (state_in),
        .d        (d_next)
    );

    assign s2_ready = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign s1_fire  = s1_valid && s2_ready;

`ifdef KECCAK_THETA_BYPASS_EN
    logic s1_bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_bypass <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_bypass <= bypass;
        end
    end

    assign apply_theta = !s1_bypass;
`else
    assign apply_theta = 1'b1;
`endif

    // Stage 1: capture the raw state together with its five D lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_state <= '0;
            s1_d     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_state <= state_in;
                s1_d     <= d_next;
            end
        end
    end

    always_comb begin
        theta_out = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            theta_out[i*LANE_W +: LANE_W] = s1_state[i*LANE_W +: LANE_W] ^
                (apply_theta ? s1_d[(i % NUM_COLS)*LANE_W +: LANE_W] : {LANE_W{1'b0}});
        end
    end

    // Stage 2: result register; keeps its last value once the pipe drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            state_out <= '0;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
            end
            if (s1_fire) begin
                state_out <= theta_out;
            end
        end
    end

    assign out_valid = s2_valid;
    assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_theta_stage.sv
// Bench for theta_stage (LANE_W=64): scenario tasks plus an output scoreboard.
// Bypass scenario is built when KECCAK_THETA_BYPASS_EN is defined.
module tb_theta_stage;

    localparam int LW      = 64;
    localparam int STATE_W = 25 * LW;

    logic               clk       = 1'b0;
    logic               rst       = 1'b1;
    logic               in_valid  = 1'b0;
    logic               out_ready = 1'b0;
    logic [STATE_W-1:0] state_in  = '0;
    logic               in_ready;
    logic               out_valid;
    logic [STATE_W-1:0] state_out;
    logic               busy;
`ifdef KECCAK_THETA_BYPASS_EN
    logic               bypass    = 1'b0;
`endif

    logic [STATE_W-1:0] exp_q[$];
    int errors        = 0;
    int checks        = 0;
    int cyc           = 0;
    int out_count     = 0;
    int first_out_cyc = 0;
    int last_out_cyc  = 0;
    int last_acc_cyc  = 0;
    logic               prev_stall = 1'b0;
    logic [STATE_W-1:0] prev_data  = '0;

    theta_stage #(.LANE_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef KECCAK_THETA_BYPASS_EN
        .bypass    (bypass),
`endif
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [STATE_W-1:0] theta_model(input logic [STATE_W-1:0] a);
        logic [LW-1:0]      c [5];
        logic [LW-1:0]      d;
        logic [STATE_W-1:0] r;
        r = '0;
        for (int x = 0; x < 5; x++) begin
            c[x] = '0;
            for (int y = 0; y < 5; y++) c[x] = c[x] ^ a[(x + 5*y)*LW +: LW];
        end
        for (int x = 0; x < 5; x++) begin
            d = c[(x + 4) % 5] ^ {c[(x + 1) % 5][LW-2:0], c[(x + 1) % 5][LW-1]};
            for (int y = 0; y < 5; y++) r[(x + 5*y)*LW +: LW] = a[(x + 5*y)*LW +: LW] ^ d;
        end
        return r;
    endfunction

    function automatic logic [STATE_W-1:0] rand_state();
        logic [STATE_W-1:0] r;
        for (int w = 0; w < STATE_W/32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [STATE_W-1:0] lane0_state();
        logic [STATE_W-1:0] r;
        r = '0;
        r[0] = 1'b1;
        return r;
    endfunction

    // Hand-derived theta of lane0=1: C[0]=1 -> D[1]=1, D[4]=2, others 0.
    function automatic logic [STATE_W-1:0] lane0_expected();
        logic [STATE_W-1:0] r;
        r = '0;
        r[0] = 1'b1;
        for (int y = 0; y < 5; y++) begin
            r[(1 + 5*y)*LW]     = 1'b1;
            r[(4 + 5*y)*LW + 1] = 1'b1;
        end
        return r;
    endfunction

    // ---------------- scoreboard / output monitor ----------------
    always @(negedge clk) begin
        logic [STATE_W-1:0] exp;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || state_out !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable cyc=%0d out_valid=%b data_changed=%b required out_valid=1 data_changed=0",
                             cyc, out_valid, state_out !== prev_data);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d got lane0=%h with empty queue", cyc, state_out[LW-1:0]);
                end else begin
                    exp = exp_q.pop_front();
                    if (state_out !== exp) begin
                        errors++;
                        for (int i = 0; i < 25; i++) begin
                            if (state_out[i*LW +: LW] !== exp[i*LW +: LW]) begin
                                $display("FAIL scoreboard cyc=%0d lane=%0d got=%h exp=%h",
                                         cyc, i, state_out[i*LW +: LW], exp[i*LW +: LW]);
                                break;
                            end
                        end
                    end
                end
                if (out_count == 0) first_out_cyc = cyc;
                out_count++;
                last_out_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = state_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [STATE_W-1:0] s, input logic b, input logic [STATE_W-1:0] e);
        bit ok;
        ok = 1'b0;
        state_in = s;
        in_valid = 1'b1;
`ifdef KECCAK_THETA_BYPASS_EN
        bypass = b;
`else
        if (b) $display("note: bypass requested but feature not built");
`endif
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout cyc=%0d in_ready=%b required 1 within 50 cycles", cyc, in_ready);
        end else begin
            exp_q.push_back(e);
            last_acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input string name);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (out_count >= n) break;
        end
        #1;
        checks++;
        if (out_count != n) begin
            errors++;
            $display("FAIL %s_count got=%0d required=%0d", name, out_count, n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        if (state_out !== '0)   begin errors++; $display("FAIL reset_state_out lane0 got=%h required=0", state_out[LW-1:0]); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got=%b required=0", out_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL post_reset_busy got=%b required=0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        out_count = 0;
        send_beat('0, 1'b0, '0);
        wait_outputs(1, "zero");
        checks++;
        if (first_out_cyc - last_acc_cyc != 2) begin
            errors++;
            $display("FAIL zero_latency got=%0d required=2", first_out_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_lane0();
        out_ready = 1'b1;
        out_count = 0;
        send_beat(lane0_state(), 1'b0, lane0_expected());
        wait_outputs(1, "lane0");
        checks++;
        if (first_out_cyc - last_acc_cyc != 2) begin
            errors++;
            $display("FAIL lane0_latency got=%0d required=2", first_out_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [STATE_W-1:0] s;
        int first_acc;
        out_ready = 1'b1;
        out_count = 0;
        first_acc = 0;
        for (int i = 0; i < 8; i++) begin
            s = rand_state();
            send_beat(s, 1'b0, theta_model(s));
            if (i == 0) first_acc = last_acc_cyc;
        end
        wait_outputs(8, "b2b");
        checks += 2;
        if (last_acc_cyc - first_acc != 7) begin
            errors++;
            $display("FAIL b2b_accept_span got=%0d required=7", last_acc_cyc - first_acc);
        end
        if (last_out_cyc - first_out_cyc != 7) begin
            errors++;
            $display("FAIL b2b_output_span got=%0d required=7", last_out_cyc - first_out_cyc);
        end
    endtask

    task automatic test_stall();
        logic [STATE_W-1:0] s [3];
        for (int i = 0; i < 3; i++) s[i] = rand_state();
        out_ready = 1'b0;
        out_count = 0;
        fork
            begin
                for (int i = 0; i < 3; i++) send_beat(s[i], 1'b0, theta_model(s[i]));
            end
            begin
                repeat (5) @(negedge clk);
                checks += 3;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b required=0", in_ready); end
                if (exp_q.size() != 2) begin errors++; $display("FAIL stall_accepted got=%0d required=2", exp_q.size()); end
                if (out_count != 0)    begin errors++; $display("FAIL stall_outputs got=%0d required=0", out_count); end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_outputs(3, "stall");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_leftover got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [STATE_W-1:0] s;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s = rand_state();
            send_beat(s, 1'b0, theta_model(s));
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b required=1", busy); end
        rst = 1'b1;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b required=0", out_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got=%b required=0", busy); end
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        out_count = 0;
        s = rand_state();
        send_beat(s, 1'b0, theta_model(s));
        wait_outputs(1, "midrst");
        checks++;
        if (first_out_cyc - last_acc_cyc != 2) begin
            errors++;
            $display("FAIL midrst_latency got=%0d required=2", first_out_cyc - last_acc_cyc);
        end
    endtask

`ifdef KECCAK_THETA_BYPASS_EN
    task automatic test_bypass();
        out_ready = 1'b1;
        out_count = 0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) send_beat(lane0_state(), 1'b1, lane0_state());
            else            send_beat(lane0_state(), 1'b0, lane0_expected());
        end
        wait_outputs(4, "bypass");
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_lane0();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef KECCAK_THETA_BYPASS_EN
        test_bypass();
`endif
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (busy !== 1'b0)     begin errors++; $display("FAIL final_busy got=%b required=0", busy); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue got=%0d required=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
